// File: rtl/boa_csr_pkg.sv
// Shared definitions for the Boa M-mode standard CSR file.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package boa_csr_pkg;

  // CSR addresses served by this overlay port
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // mstatus field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  // RV32 with the I extension only
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  typedef struct packed {
    logic [18:0] rsv_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsv_mid;
    logic        mpie;
    logic [2:0]  rsv_lo2;
    logic        mie;
    logic [2:0]  rsv_lo;
  } mstatus_t;

  // Only M (11) and U (00) exist; S and the reserved level collapse to U.
  function automatic logic [1:0] mpp_warl(input logic [1:0] v);
    return ((v == 2'b01) || (v == 2'b10)) ? 2'b00 : v;
  endfunction

endpackage

// File: rtl/boa_csr_if.sv
// CSR access bus and trap/return/interrupt bus between pipeline and CSR file.
// Latency: reads are combinational; writes and events commit at the clock edge.
// Backpressure: none; every access and event is accepted in its cycle.
interface boa_csr_bus;
  logic [11:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exists;
  logic        rdonly;
  logic [1:0]  priv;

  modport CSR (input addr, we, wdata, output rdata, exists, rdonly, priv);
  modport CPU (output addr, we, wdata, input rdata, exists, rdonly, priv);
endinterface

interface boa_csr_ex_bus;
  logic        ex_trap;
  logic        ex_irq;
  logic [4:0]  ex_cause;
  logic [30:0] ex_epc;
  logic [1:0]  ex_pp;
  logic [1:0]  ex_priv;
  logic        ret;
  logic [31:0] irq_ip;
  logic [29:0] ex_tvec;
  logic [1:0]  ret_pp;
  logic [30:0] ret_epc;
  logic [31:0] irq_mie;
  logic [31:0] irq_mideleg;
  logic [31:0] irq_medeleg;
  logic [31:0] irq_sie;

  modport CSR (input ex_trap, ex_irq, ex_cause, ex_epc, ex_pp, ex_priv, ret, irq_ip,
               output ex_tvec, ret_pp, ret_epc, irq_mie, irq_mideleg, irq_medeleg, irq_sie);
  modport CPU (output ex_trap, ex_irq, ex_cause, ex_epc, ex_pp, ex_priv, ret, irq_ip,
               input ex_tvec, ret_pp, ret_epc, irq_mie, irq_mideleg, irq_medeleg, irq_sie);
endinterface

// File: rtl/boa_csr_counter64.sv
// 64-bit event counter with per-half 32-bit load.
// Latency: new value visible one cycle after the edge that loads/increments it.
// Backpressure: none; a load in either half suppresses that cycle's increment.
module boa_csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // A load wins over counting; the 64-bit add carries into the high word in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) cnt_d[31:0]  = wdata_i;
      if (we_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/boa_csr_mstd.sv
// M-mode standard CSR file: trap CSRs, ID CSRs and (with BOA_CSR_COUNTERS_EN) cycle/instret.
// Latency: 0-cycle combinational read; writes, traps and returns commit at the clock edge.
// Backpressure: none; per field a trap beats a return, which beats a CSR write.
module boa_csr_mstd
  import boa_csr_pkg::*;
#(
  parameter logic [31:0] HARTID      = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   retire,
  boa_csr_bus.CSR    csr,
  boa_csr_ex_bus.CSR ex
);

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [1:0]  st_mpp_q, st_mpp_d;
  logic [31:0] mie_q, mie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [30:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic        rd_exists;
  logic [31:0] rd_val;
  mstatus_t    st_view;
  logic        wr_en;
  logic        trap;
  logic        unused_sig;

  assign trap  = ex.ex_trap | ex.ex_irq;
  assign wr_en = csr.we && rd_exists && (csr.addr[11:10] != 2'b11);

`ifdef BOA_CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  boa_csr_counter64 u_mcycle (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (1'b1),
    .we_lo_i (wr_en && (csr.addr == CSR_MCYCLE)),
    .we_hi_i (wr_en && (csr.addr == CSR_MCYCLEH)),
    .wdata_i (csr.wdata),
    .cnt_o   (mcycle)
  );

  boa_csr_counter64 u_minstret (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (retire),
    .we_lo_i (wr_en && (csr.addr == CSR_MINSTRET)),
    .we_hi_i (wr_en && (csr.addr == CSR_MINSTRETH)),
    .wdata_i (csr.wdata),
    .cnt_o   (minstret)
  );

  assign unused_sig = ^ex.ex_priv;
`else
  assign unused_sig = ^{ex.ex_priv, retire};
`endif

  // Address decode and read mux; unknown addresses read as all-zero and not existing.
  always_comb begin
    st_view      = '0;
    st_view.mie  = st_mie_q;
    st_view.mpie = st_mpie_q;
    st_view.mpp  = st_mpp_q;
    rd_exists    = 1'b1;
    rd_val       = '0;
    case (csr.addr)
      CSR_MSTATUS:  rd_val = st_view;
      CSR_MISA:     rd_val = MISA_VAL;
      CSR_MIE:      rd_val = mie_q;
      CSR_MTVEC:    rd_val = {mtvec_q, 2'b00};
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = {mepc_q, 1'b0};
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MIP:      rd_val = ex.irq_ip;
      CSR_MHARTID:  rd_val = HARTID;
`ifdef BOA_CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
`endif
      default:      rd_exists = 1'b0;
    endcase
  end

  assign csr.exists = rd_exists;
  assign csr.rdata  = rd_val;
  assign csr.rdonly = rd_exists && (csr.addr[11:10] == 2'b11);
  assign csr.priv   = rd_exists ? csr.addr[9:8] : 2'b00;

  // Next state: write first, then return, then trap, so later assignments win per field.
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    st_mpp_d   = st_mpp_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (wr_en) begin
      case (csr.addr)
        CSR_MSTATUS: begin
          st_mie_d  = csr.wdata[MSTATUS_MIE_BIT];
          st_mpie_d = csr.wdata[MSTATUS_MPIE_BIT];
          st_mpp_d  = mpp_warl(csr.wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        end
        CSR_MIE:      mie_d      = csr.wdata;
        CSR_MTVEC:    mtvec_d    = csr.wdata[31:2];
        CSR_MSCRATCH: mscratch_d = csr.wdata;
        CSR_MEPC:     mepc_d     = csr.wdata[31:1];
        CSR_MCAUSE:   mcause_d   = csr.wdata;
        default:      ;
      endcase
    end
    if (ex.ret) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
      st_mpp_d  = 2'b00;
    end
    if (trap) begin
      mepc_d    = ex.ex_epc;
      mcause_d  = {ex.ex_irq, 26'b0, ex.ex_cause};
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      st_mpp_d  = ex.ex_pp;
    end
  end

  // CSR state registers; reset drops any update in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      st_mpp_q   <= 2'b11;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      st_mpp_q   <= st_mpp_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign ex.ex_tvec     = mtvec_q;
  assign ex.ret_pp      = st_mpp_q;
  assign ex.ret_epc     = mepc_q;
  assign ex.irq_mie     = st_mie_q ? mie_q : 32'b0;
  assign ex.irq_mideleg = 32'b0;
  assign ex.irq_medeleg = 32'b0;
  assign ex.irq_sie     = 32'b0;

endmodule
